svo_fb_bank_arbiter: RTL

//  Owns the single-port RGB444 pixel RAM behind the SVO frame-buffer read port; holds two banks (double buffer).

---
 rtl/svo_fb_bank_arbiter_pkg.sv | 20 ++
 rtl/svo_fb_bank_arbiter_addr_gen.sv | 39 +++
 rtl/svo_fb_bank_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/svo_fb_bank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// svo_fb_bank_arbiter_pkg
// Shared definitions for the SVO frame-buffer bank arbiter:
//   - default frame geometry, pixel width and per-bank address width
//   - write-side FSM state encoding (WR_ACTIVE / WR_HOLD / WR_SKIP)
// ---------------------------------------------------------------------------
package svo_fb_bank_arbiter_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int PIX_W_DEF     = 12;
  localparam int ADDR_W_DEF    = 17;

  typedef enum logic [1:0] {
    WR_ACTIVE = 2'd0,
    WR_HOLD   = 2'd1,
    WR_SKIP   = 2'd2
  } wr_state_t;

endpackage

// File: rtl/svo_fb_bank_arbiter_addr_gen.sv
// ---------------------------------------------------------------------------
// svo_fb_bank_arbiter_addr_gen
// Purely combinational (x,y) -> linear pixel address converter.
// Ports:
//   i_x        [9:0]        pixel column
//   i_y        [8:0]        pixel line
//   o_lin      [ADDR_W-1:0] y*FB_WIDTH + x
//   o_in_range              1 when x < FB_WIDTH and y < FB_HEIGHT
// ---------------------------------------------------------------------------
module svo_fb_bank_arbiter_addr_gen
  import svo_fb_bank_arbiter_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  output logic [ADDR_W-1:0] o_lin,
  output logic              o_in_range
);

  localparam logic [ADDR_W-1:0] LP_WIDTH  = ADDR_W'(FB_WIDTH);
  localparam logic [31:0]       LP_X_LIM  = 32'(FB_WIDTH);
  localparam logic [31:0]       LP_Y_LIM  = 32'(FB_HEIGHT);

  // Range test done at 32 bits so geometries that fill the coordinate
  // width (e.g. 1024 columns) still compare correctly.
  logic [31:0] w_x32;
  logic [31:0] w_y32;

  assign w_x32      = {22'd0, i_x};
  assign w_y32      = {23'd0, i_y};
  assign o_in_range = (w_x32 < LP_X_LIM) && (w_y32 < LP_Y_LIM);

  // Out-of-range coordinates may wrap here; callers gate on o_in_range.
  assign o_lin = ADDR_W'(i_y) * LP_WIDTH + ADDR_W'(i_x);

endmodule

// File: rtl/svo_fb_bank_arbiter.sv
// ---------------------------------------------------------------------------
// svo_fb_bank_arbiter
// Double-buffered RGB444 frame buffer front end. Owns one single-port RAM
// split into two banks: the camera writer fills wr_bank while the VDMA
// reader scans rd_bank. Reader always wins the RAM; the writer stalls.
// Banks swap only at frame boundaries and only once the reader has
// finished a complete frame, so the reader never sees a torn image.
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_wr_req/x/y/data         camera pixel write (held until o_wr_ack)
//   i_wr_frame_end            pulse after the last pixel of a camera frame
//   o_wr_ack                  write accepted or discarded this cycle
//   i_fb_read_req/x/y         VDMA read strobe and coordinate
//   o_fb_read_data            read pixel, one cycle after the strobe
//   o_fb_frame_ready          pulse: new complete frame in read bank
//   o_ram_en/we/addr/wdata    RAM strobes, {bank, linear} address, data
//   i_ram_rdata               RAM registered read data
//   o_frame_count             completed swaps (wraps)
//   o_drop_count              camera frames discarded (wraps)
// ---------------------------------------------------------------------------
module svo_fb_bank_arbiter
  import svo_fb_bank_arbiter_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic [9:0]        i_wr_x,
  input  logic [8:0]        i_wr_y,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic              i_wr_frame_end,
  output logic              o_wr_ack,
  input  logic              i_fb_read_req,
  input  logic [9:0]        i_fb_read_x,
  input  logic [8:0]        i_fb_read_y,
  output logic [PIX_W-1:0]  o_fb_read_data,
  output logic              o_fb_frame_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W:0]   o_ram_addr,
  output logic [PIX_W-1:0]  o_ram_wdata,
  input  logic [PIX_W-1:0]  i_ram_rdata,
  output logic [15:0]       o_frame_count,
  output logic [15:0]       o_drop_count
);

  localparam logic [ADDR_W-1:0] LP_LAST_RD = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic              r_rd_busy;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_rd_ok;
  logic              r_frame_ready;
  logic [15:0]       r_frame_count;
  logic [15:0]       r_drop_count;

  logic [ADDR_W-1:0] w_rd_lin;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_wr_lin;
  logic              w_wr_in_range;
  logic              w_rd_sel;
  logic              w_wr_sel;
  logic              w_wr_commit;
  logic              w_last_read;
  logic              w_busy_eff;
  logic              w_swap;
  logic              w_drop;

  svo_fb_bank_arbiter_addr_gen #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .ADDR_W   (ADDR_W)
  ) u_rd_addr (
    .i_x       (i_fb_read_x),
    .i_y       (i_fb_read_y),
    .o_lin     (w_rd_lin),
    .o_in_range(w_rd_in_range)
  );

  svo_fb_bank_arbiter_addr_gen #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .ADDR_W   (ADDR_W)
  ) u_wr_addr (
    .i_x       (i_wr_x),
    .i_y       (i_wr_y),
    .o_lin     (w_wr_lin),
    .o_in_range(w_wr_in_range)
  );

  // Strobes are gated by reset so every output reads zero while reset is high.
  assign w_rd_sel    = ~i_reset & i_fb_read_req;
  assign w_wr_sel    = ~i_reset & ~i_fb_read_req & i_wr_req;
  assign w_wr_commit = w_wr_sel & (r_state == WR_ACTIVE) & w_wr_in_range;

  // Treating the final read of a frame as "not busy" lets a coincident
  // frame end swap immediately instead of detouring through WR_HOLD.
  assign w_last_read = r_rd_busy & i_fb_read_req & (r_rd_cnt == LP_LAST_RD);
  assign w_busy_eff  = r_rd_busy & ~w_last_read;

  assign o_wr_ack         = w_wr_sel;
  assign o_ram_en         = w_rd_sel | w_wr_commit;
  assign o_ram_we         = w_wr_commit;
  assign o_fb_read_data   = r_rd_ok ? i_ram_rdata : '0;
  assign o_fb_frame_ready = r_frame_ready;
  assign o_frame_count    = r_frame_count;
  assign o_drop_count     = r_drop_count;

  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_rd_sel) begin
      o_ram_addr = {r_rd_bank, w_rd_lin};
    end else if (w_wr_commit) begin
      o_ram_addr  = {r_wr_bank, w_wr_lin};
      o_ram_wdata = i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= WR_ACTIVE;
    else         r_state <= w_state_next;
  end

  // A frame ending in HOLD on the same cycle the reader frees up is still
  // dropped; the writer then resumes on the next frame without skipping.
  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      WR_ACTIVE: begin
        if (i_wr_frame_end) begin
          if (w_busy_eff) w_state_next = WR_HOLD;
          else            w_swap       = 1'b1;
        end
      end
      WR_HOLD: begin
        if (!w_busy_eff) begin
          w_swap = 1'b1;
          if (i_wr_frame_end) begin
            w_drop       = 1'b1;
            w_state_next = WR_ACTIVE;
          end else begin
            w_state_next = WR_SKIP;
          end
        end else if (i_wr_frame_end) begin
          w_drop = 1'b1;
        end
      end
      WR_SKIP: begin
        if (i_wr_frame_end) w_state_next = WR_ACTIVE;
      end
      default: w_state_next = WR_ACTIVE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_rd_busy     <= 1'b0;
      r_rd_cnt      <= '0;
      r_rd_ok       <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_count <= 16'd0;
      r_drop_count  <= 16'd0;
    end else begin
      r_rd_ok       <= w_rd_sel & w_rd_in_range;
      r_frame_ready <= w_swap;
      if (w_drop) r_drop_count <= r_drop_count + 16'd1;
      if (w_swap) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= ~r_wr_bank;
        r_rd_busy     <= 1'b1;
        r_rd_cnt      <= '0;
        r_frame_count <= r_frame_count + 16'd1;
      end else if (w_last_read) begin
        r_rd_busy <= 1'b0;
        r_rd_cnt  <= '0;
      end else if (r_rd_busy && i_fb_read_req) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

endmodule
